// File: rtl/eu_xbuf_wr_arb_if.sv
// eu_xbuf_wr_arb_if -- bundles the writer request bus and the single
// eu_xbuf input port that the write arbiter shares between them.
// ADDR_W / DATA_W are the widths of type_exec_unit_addr / type_exec_unit_data.
// The master modport is taken by the arbiter; the slave modport is taken by
// whatever drives the writers and models the eu_xbuf input port.
interface eu_xbuf_wr_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64
);
  logic [NUM_REQ-1:0]        wr_valid_i;
  logic [NUM_REQ*ADDR_W-1:0] wr_addr_i;
  logic [NUM_REQ*DATA_W-1:0] wr_data_i;
  logic [NUM_REQ-1:0]        wr_grant_o;
  logic [ADDR_W-1:0]         xbuf_addr_o;
  logic [DATA_W-1:0]         xbuf_data_o;
  logic                      xbuf_valid_o;
  logic                      xbuf_success_i;

  modport master (
    input  wr_valid_i, wr_addr_i, wr_data_i, xbuf_success_i,
    output wr_grant_o, xbuf_addr_o, xbuf_data_o, xbuf_valid_o
  );

  modport slave (
    output wr_valid_i, wr_addr_i, wr_data_i, xbuf_success_i,
    input  wr_grant_o, xbuf_addr_o, xbuf_data_o, xbuf_valid_o
  );
endinterface

// File: rtl/eu_xbuf_wr_arb.sv
// eu_xbuf_wr_arb -- round-robin arbiter that lets NUM_REQ writers share one
// eu_xbuf input port. An owner is held until its entry is accepted, its
// request drops, or it stalls STALL_LIMIT cycles, after which a one-cycle
// BACKOFF hands the port to the next writer so nobody can lock it.
// Optional feature macro: EU_XBUF_ARB_STATS_EN adds grant/abort counters.
module eu_xbuf_wr_arb #(
  parameter int NUM_REQ     = 4,
  parameter int STALL_LIMIT = 7,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64
) (
  input  logic clk,
  input  logic reset,
`ifdef EU_XBUF_ARB_STATS_EN
  output logic [15:0] grant_cnt_o,
  output logic [15:0] abort_cnt_o,
`endif
  eu_xbuf_wr_arb_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_BACKOFF = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [IDX_W-1:0] sel_r, sel_s;
  logic [IDX_W-1:0] rr_ptr_r, rr_ptr_s;
  logic [7:0]       stall_cnt_r, stall_cnt_s;

  logic [NUM_REQ-1:0] grant_s;
  logic               valid_s;
  logic [IDX_W:0]     pick_idle_s;
  logic [IDX_W:0]     pick_next_s;
  logic [NUM_REQ-1:0] others_s;
  logic [IDX_W-1:0]   sel_inc_s;

  // Next index after idx, wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) begin
      return '0;
    end else begin
      return idx + IDX_W'(1);
    end
  endfunction

  // First set bit searching upward from start with wrap; MSB = found flag.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] vec,
                                             input logic [IDX_W-1:0]   start);
    logic [IDX_W:0] res;
    int             j;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = (int'(start) + i) % NUM_REQ;
      if (vec[j]) begin
        res = {1'b1, IDX_W'(j)};
      end
    end
    return res;
  endfunction

  // Candidate selections for IDLE entry and for back-to-back handover.
  always_comb begin
    sel_inc_s   = idx_inc(sel_r);
    others_s    = bus.wr_valid_i & ~(NUM_REQ'(1) << sel_r);
    pick_idle_s = rr_pick(bus.wr_valid_i, rr_ptr_r);
    pick_next_s = rr_pick(others_s, sel_inc_s);
  end

  // Next-state logic and combinational valid/grant outputs.
  always_comb begin
    state_s     = state_r;
    sel_s       = sel_r;
    rr_ptr_s    = rr_ptr_r;
    stall_cnt_s = stall_cnt_r;
    grant_s     = '0;
    valid_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_idle_s[IDX_W]) begin
          sel_s   = pick_idle_s[IDX_W-1:0];
          state_s = ST_HOLD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        valid_s = bus.wr_valid_i[sel_r];
        if (!bus.wr_valid_i[sel_r]) begin
          // Owner withdrew: release without grant, keep the rotation point.
          stall_cnt_s = 8'd0;
          state_s     = ST_IDLE;
        end else if (bus.xbuf_success_i) begin
          grant_s[sel_r] = 1'b1;
          rr_ptr_s       = sel_inc_s;
          stall_cnt_s    = 8'd0;
          if (pick_next_s[IDX_W]) begin
            sel_s   = pick_next_s[IDX_W-1:0];
            state_s = ST_HOLD;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (stall_cnt_r == 8'(STALL_LIMIT - 1)) begin
          // Owner blocked too long: skip past it so others get a turn.
          rr_ptr_s    = sel_inc_s;
          stall_cnt_s = 8'd0;
          state_s     = ST_BACKOFF;
        end else begin
          stall_cnt_s = stall_cnt_r + 8'd1;
        end
      end
      ST_BACKOFF: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s     = ST_IDLE;
        sel_s       = '0;
        rr_ptr_s    = '0;
        stall_cnt_s = 8'd0;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      sel_r       <= '0;
      rr_ptr_r    <= '0;
      stall_cnt_r <= 8'd0;
    end else begin
      state_r     <= state_s;
      sel_r       <= sel_s;
      rr_ptr_r    <= rr_ptr_s;
      stall_cnt_r <= stall_cnt_s;
    end
  end

  // Drive the shared port from the current owner's slice.
  always_comb begin
    bus.xbuf_valid_o = valid_s & ~reset;
    bus.wr_grant_o   = grant_s & {NUM_REQ{~reset}};
    bus.xbuf_addr_o  = bus.wr_addr_i[sel_r*ADDR_W +: ADDR_W];
    bus.xbuf_data_o  = bus.wr_data_i[sel_r*DATA_W +: DATA_W];
  end

`ifdef EU_XBUF_ARB_STATS_EN
  logic [15:0] grant_cnt_r, abort_cnt_r;

  // Wrapping counters of accepted transfers and stall aborts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt_r <= 16'd0;
      abort_cnt_r <= 16'd0;
    end else begin
      if (|grant_s) begin
        grant_cnt_r <= grant_cnt_r + 16'd1;
      end
      if ((state_r == ST_HOLD) && (state_s == ST_BACKOFF)) begin
        abort_cnt_r <= abort_cnt_r + 16'd1;
      end
    end
  end

  assign grant_cnt_o = grant_cnt_r;
  assign abort_cnt_o = abort_cnt_r;
`endif

endmodule

// File: tb/tb_eu_xbuf_wr_arb.sv
// Directed bench for eu_xbuf_wr_arb: NUM_REQ=4, STALL_LIMIT=7.
module tb_eu_xbuf_wr_arb;
  localparam int NR = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

`ifdef EU_XBUF_ARB_STATS_EN
  logic [15:0] grant_cnt;
  logic [15:0] abort_cnt;
`endif

  eu_xbuf_wr_arb_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  eu_xbuf_wr_arb #(.NUM_REQ(NR), .STALL_LIMIT(7), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef EU_XBUF_ARB_STATS_EN
    .grant_cnt_o(grant_cnt),
    .abort_cnt_o(abort_cnt),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vg(input string tag, input logic v, input logic [3:0] g);
    chk({tag, ".valid"}, 64'(bus.xbuf_valid_o), 64'(v));
    chk({tag, ".grant"}, 64'(bus.wr_grant_o), 64'(g));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.wr_valid_i     = 4'b0000;
    bus.xbuf_success_i = 1'b0;
    bus.wr_addr_i      = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    bus.wr_data_i      = {32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000};

    // Reset state
    #2;
    chk_vg("reset", 1'b0, 4'b0000);
    chk("reset.addr", 64'(bus.xbuf_addr_o), 64'hA000);
    nxt();
    reset = 1'b0;

    // All four valid, success every cycle: rotation 0,1,2,3,0
    bus.wr_valid_i     = 4'b1111;
    bus.xbuf_success_i = 1'b1;
    @(negedge clk);
    chk_vg("rr.idle", 1'b0, 4'b0000);
    nxt();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_vg("rr.hold", 1'b1, 4'(1 << (k % 4)));
      chk("rr.addr", 64'(bus.xbuf_addr_o), 64'(16'hA000 + 16'(k % 4)));
      nxt();
    end
    // Owner (writer 1) withdraws: no grant, back to IDLE
    bus.wr_valid_i = 4'b0000;
    @(negedge clk);
    chk_vg("drop", 1'b0, 4'b0000);
    nxt();

    // Only writer 2 valid, success tied 1
    bus.wr_valid_i = 4'b0100;
    @(negedge clk);
    chk_vg("w2.idle", 1'b0, 4'b0000);
    chk("w2.idle_addr", 64'(bus.xbuf_addr_o), 64'hA001);
    nxt();
    @(negedge clk);
    chk_vg("w2.hold", 1'b1, 4'b0100);
    chk("w2.addr", 64'(bus.xbuf_addr_o), 64'hA002);
    chk("w2.data", 64'(bus.xbuf_data_o), 64'hD0000002);
    nxt();
    bus.wr_valid_i = 4'b0000;
    @(negedge clk);
    chk_vg("w2.after", 1'b0, 4'b0000);
    nxt();

    // Writer 1 valid, success 0: 7 HOLD, 1 BACKOFF, IDLE, re-selected
    bus.wr_valid_i     = 4'b0010;
    bus.xbuf_success_i = 1'b0;
    @(negedge clk);
    chk_vg("st.idle", 1'b0, 4'b0000);
    nxt();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk_vg("st.hold", 1'b1, 4'b0000);
      nxt();
    end
    @(negedge clk);
    chk_vg("st.backoff", 1'b0, 4'b0000);
    nxt();
    @(negedge clk);
    chk_vg("st.idle2", 1'b0, 4'b0000);
    nxt();
    bus.xbuf_success_i = 1'b1;
    @(negedge clk);
    chk_vg("st.regrant", 1'b1, 4'b0010);
    chk("st.addr", 64'(bus.xbuf_addr_o), 64'hA001);
    nxt();
    bus.wr_valid_i     = 4'b0000;
    bus.xbuf_success_i = 1'b0;

    // Reset mid-HOLD with writer 2 owning
    bus.wr_valid_i = 4'b0100;
    @(negedge clk);
    chk_vg("rh.idle", 1'b0, 4'b0000);
    nxt();
    @(negedge clk);
    chk_vg("rh.hold", 1'b1, 4'b0000);
    reset = 1'b1;
    #1;
    chk_vg("rh.reset", 1'b0, 4'b0000);
    chk("rh.addr", 64'(bus.xbuf_addr_o), 64'hA000);
    nxt();
    reset = 1'b0;

    // Writers 0 and 3: writer 0 wins after reset, stalls out, writer 3 next
    bus.wr_valid_i = 4'b1001;
    @(negedge clk);
    chk_vg("ab.idle", 1'b0, 4'b0000);
    nxt();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk_vg("ab.hold", 1'b1, 4'b0000);
      chk("ab.addr", 64'(bus.xbuf_addr_o), 64'hA000);
      nxt();
    end
    @(negedge clk);
    chk_vg("ab.backoff", 1'b0, 4'b0000);
    nxt();
    @(negedge clk);
    chk_vg("ab.idle2", 1'b0, 4'b0000);
    nxt();
    bus.xbuf_success_i = 1'b1;
    @(negedge clk);
    chk_vg("ab.w3", 1'b1, 4'b1000);
    chk("ab.w3addr", 64'(bus.xbuf_addr_o), 64'hA003);
    nxt();
    @(negedge clk);
    chk_vg("ab.w0", 1'b1, 4'b0001);
    nxt();
    bus.wr_valid_i = 4'b0000;
    @(negedge clk);
    chk_vg("ab.drop", 1'b0, 4'b0000);

`ifdef EU_XBUF_ARB_STATS_EN
    chk("stats.grant", 64'(grant_cnt), 64'd2);
    chk("stats.abort", 64'(abort_cnt), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
